// File: rtl/mlab_delay_pkg.sv
// Shared types and limits for the MLAB delay-line monitor.
package mlab_delay_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  localparam int unsigned LAT_MIN = 3;
  localparam int unsigned LAT_MAX = 33;

  // Flush counter must hold any legal LATENCY value.
  function automatic int unsigned fcnt_width();
    return $clog2(LAT_MAX + 1);
  endfunction

endpackage

// File: rtl/mlab_delay_monitor_valid_delay_line.sv
// 1-bit enabled shift register carrying word-valid alongside the data delay line.
module valid_delay_line #(
  parameter int unsigned DEPTH = 10
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic d_i,
  output logic q_o
);

  logic [DEPTH-1:0] pipe_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pipe_q <= '0;
    end else if (en_i) begin
      pipe_q <= {pipe_q[DEPTH-2:0], d_i};
    end
  end

  assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/mlab_delay_monitor.sv
// Output stage of the MLAB delay line: registers data, qualifies parity errors,
// suppresses valid while the read pointer re-syncs, and counts errors.
module mlab_delay_monitor
  import mlab_delay_pkg::*;
#(
  parameter int unsigned WIDTH    = 414,
  parameter int unsigned LATENCY  = 10,
  parameter int unsigned CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                arst,
  input  logic                ena,
  input  logic                din_valid,
  input  logic [WIDTH-1:0]    dly_dout,
  input  logic                dly_perr,
  input  logic                err_clear,
  output logic [WIDTH-1:0]    dout,
  output logic                dout_valid,
  output logic                recovering,
  output logic                err_sticky,
  output logic [CNT_BITS-1:0] err_count
);

  localparam int unsigned FCNT_W = fcnt_width();

  if (LATENCY < LAT_MIN || LATENCY > LAT_MAX) begin : g_bad_latency
    $error("mlab_delay_monitor: LATENCY %0d outside %0d..%0d", LATENCY, LAT_MIN, LAT_MAX);
  end

  logic                vtail;
  logic                qerr;
  state_e              state_q, state_d;
  logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
  logic [WIDTH-1:0]    dout_q, dout_d;
  logic                dout_valid_q, dout_valid_d;
  logic                recovering_q, recovering_d;
  logic                sticky_q, sticky_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;

  valid_delay_line #(
    .DEPTH (LATENCY)
  ) u_vdl (
    .clk_i (clk),
    .rst_i (arst),
    .en_i  (ena),
    .d_i   (din_valid),
    .q_o   (vtail)
  );

  // Parity errors only matter on words that were actually valid.
  assign qerr = ena & dly_perr & vtail;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q      <= ST_RUN;
      fcnt_q       <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      recovering_q <= 1'b0;
      sticky_q     <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      fcnt_q       <= fcnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      recovering_q <= recovering_d;
      sticky_q     <= sticky_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    fcnt_d       = fcnt_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    cnt_d        = cnt_q;
    sticky_d     = sticky_q;

    unique case (state_q)
      ST_RUN: begin
        if (qerr) begin
          state_d = ST_FLUSH;
          fcnt_d  = FCNT_W'(LATENCY);
        end
      end
      ST_FLUSH: begin
        // A fresh error restarts the re-sync window.
        if (qerr) begin
          fcnt_d = FCNT_W'(LATENCY);
        end else if (ena) begin
          if (fcnt_q == FCNT_W'(1)) begin
            state_d = ST_RUN;
            fcnt_d  = '0;
          end else begin
            fcnt_d = fcnt_q - FCNT_W'(1);
          end
        end
      end
    endcase

    if (ena) begin
      dout_d       = dly_dout;
      dout_valid_d = vtail & ~qerr & (state_q == ST_RUN);
    end

    // An error in the same cycle as a clear survives the clear.
    if (qerr) begin
      sticky_d = 1'b1;
      if (err_clear) begin
        cnt_d = CNT_BITS'(1);
      end else if (cnt_q != '1) begin
        cnt_d = cnt_q + CNT_BITS'(1);
      end
    end else if (err_clear) begin
      sticky_d = 1'b0;
      cnt_d    = '0;
    end

    recovering_d = (state_d == ST_FLUSH);
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign recovering = recovering_q;
  assign err_sticky = sticky_q;
  assign err_count  = cnt_q;

endmodule

// File: tb/tb_mlab_delay_monitor.sv
// Directed bench for mlab_delay_monitor: scenario table plus hand-written corner sequences.
module tb_mlab_delay_monitor;

  localparam int unsigned W = 414;
  localparam int unsigned L = 10;

  logic         clk = 1'b0;
  logic         arst;
  logic         ena;
  logic         din_valid;
  logic [W-1:0] dly_dout;
  logic         dly_perr;
  logic         err_clear;

  logic [W-1:0] dout, s_dout;
  logic         dout_valid, s_dout_valid;
  logic         recovering, s_recovering;
  logic         err_sticky, s_err_sticky;
  logic [15:0]  err_count;
  logic [3:0]   s_err_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mlab_delay_monitor #(.WIDTH(W), .LATENCY(L), .CNT_BITS(16)) u_dut (
    .clk(clk), .arst(arst), .ena(ena), .din_valid(din_valid), .dly_dout(dly_dout),
    .dly_perr(dly_perr), .err_clear(err_clear), .dout(dout), .dout_valid(dout_valid),
    .recovering(recovering), .err_sticky(err_sticky), .err_count(err_count)
  );

  mlab_delay_monitor #(.WIDTH(W), .LATENCY(L), .CNT_BITS(4)) u_sat (
    .clk(clk), .arst(arst), .ena(ena), .din_valid(din_valid), .dly_dout(dly_dout),
    .dly_perr(dly_perr), .err_clear(err_clear), .dout(s_dout), .dout_valid(s_dout_valid),
    .recovering(s_recovering), .err_sticky(s_err_sticky), .err_count(s_err_count)
  );

  typedef struct {
    int   perr_a;   // word index with parity error (-1: none)
    int   perr_b;
    int   inv_lo;   // range of words expected invalid (-1: none)
    int   inv_hi;
    int   rec_lo;   // edge range where recovering is expected high
    int   rec_hi;
    int   cnt;
    logic sticky;
  } scen_t;

  scen_t tbl [4];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] pat(input int c);
    logic [415:0] t;
    t = {13{(32'(c) * 32'h9E3779B1) ^ 32'h5A5A0F0F}};
    return t[W-1:0];
  endfunction

  task automatic step(input logic e, input logic dv, input logic pe, input logic clr,
                      input logic [W-1:0] d);
    ena       = e;
    din_valid = dv;
    dly_perr  = pe;
    err_clear = clr;
    dly_dout  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    arst      = 1'b1;
    ena       = 1'b0;
    din_valid = 1'b0;
    dly_perr  = 1'b0;
    err_clear = 1'b0;
    dly_dout  = '0;
    @(posedge clk);
    #1;
    arst = 1'b0;
  endtask

  initial begin
    int n;
    logic pe;
    logic ev;
    int w;

    tbl[0] = '{-1, -1, -1, -1, -1, -1, 0, 1'b0};
    tbl[1] = '{20, -1, 20, 30, 30, 39, 1, 1'b1};
    tbl[2] = '{20, 25, 20, 35, 30, 44, 2, 1'b1};
    tbl[3] = '{55, -1, -1, -1, -1, -1, 0, 1'b0};

    // Reset state, with data present on the inputs
    arst = 1'b1; ena = 1'b1; din_valid = 1'b1; dly_perr = 1'b1; err_clear = 1'b0;
    dly_dout = pat(7);
    @(posedge clk);
    #1;
    chk("rst_dout", dout, '0);
    chk("rst_valid", W'(dout_valid), '0);
    chk("rst_recov", W'(recovering), '0);
    chk("rst_sticky", W'(err_sticky), '0);
    chk("rst_count", W'(err_count), '0);

    // Scenario table: 50-word stream with optional parity errors
    for (int s = 0; s < 4; s++) begin
      do_reset();
      for (int c = 0; c < 70; c++) begin
        w  = c - int'(L);
        pe = (tbl[s].perr_a >= 0 && w == tbl[s].perr_a) ||
             (tbl[s].perr_b >= 0 && w == tbl[s].perr_b);
        step(1'b1, c < 50, pe, 1'b0, pat(c));
        ev = (w >= 0) && (w < 50) && !(w >= tbl[s].inv_lo && w <= tbl[s].inv_hi);
        chk($sformatf("s%0d_valid[%0d]", s, c), W'(dout_valid), W'(ev));
        chk($sformatf("s%0d_recov[%0d]", s, c), W'(recovering),
            W'(c >= tbl[s].rec_lo && c <= tbl[s].rec_hi));
        chk($sformatf("s%0d_dout[%0d]", s, c), dout, pat(c));
      end
      chk($sformatf("s%0d_count", s), W'(err_count), W'(tbl[s].cnt));
      chk($sformatf("s%0d_sticky", s), W'(err_sticky), W'(tbl[s].sticky));
      chk($sformatf("s%0d_satcount", s), W'(s_err_count), W'(tbl[s].cnt));
    end

    // ena toggling with parity error held high
    do_reset();
    for (int c = 0; c < 10; c++) step(1'b1, 1'b1, 1'b0, 1'b0, pat(c));
    step(1'b1, 1'b1, 1'b1, 1'b0, pat(100));
    chk("tog_cnt0", W'(err_count), W'(1));
    chk("tog_dout0", dout, pat(100));
    step(1'b0, 1'b1, 1'b1, 1'b0, pat(101));
    chk("tog_cnt1", W'(err_count), W'(1));
    chk("tog_dout1", dout, pat(100));
    chk("tog_recov1", W'(recovering), W'(1));
    step(1'b1, 1'b1, 1'b1, 1'b0, pat(102));
    chk("tog_cnt2", W'(err_count), W'(2));
    step(1'b0, 1'b1, 1'b1, 1'b0, pat(103));
    chk("tog_cnt3", W'(err_count), W'(2));
    chk("tog_dout3", dout, pat(102));
    n = 0;
    for (int i = 0; i < 24; i++) begin
      step((i % 2) == 0, 1'b1, 1'b0, 1'b0, pat(200 + i));
      if ((i % 2) == 0) n++;
      chk($sformatf("tog_flush[%0d]", i), W'(recovering), W'(n < 10));
    end
    chk("tog_cnt_end", W'(err_count), W'(2));
    chk("tog_valid_end", W'(dout_valid), W'(1));

    // Saturation and clear priority
    do_reset();
    for (int c = 0; c < 50; c++)
      step(1'b1, 1'b1, (c >= 10) && ((c % 2) == 0), 1'b0, pat(c));
    chk("sat_big", W'(err_count), W'(20));
    chk("sat_small", W'(s_err_count), W'(15));
    chk("sat_sticky", W'(s_err_sticky), W'(1));
    step(1'b1, 1'b0, 1'b0, 1'b1, pat(50));
    chk("clr_count", W'(err_count), '0);
    chk("clr_sticky", W'(err_sticky), '0);
    chk("clr_satcount", W'(s_err_count), '0);
    step(1'b1, 1'b1, 1'b1, 1'b1, pat(51));
    chk("clrerr_count", W'(err_count), W'(1));
    chk("clrerr_sticky", W'(err_sticky), W'(1));
    chk("clrerr_satcount", W'(s_err_count), W'(1));
    step(1'b0, 1'b1, 1'b1, 1'b1, pat(52));
    chk("clr_frozen_count", W'(err_count), '0);
    chk("clr_frozen_sticky", W'(err_sticky), '0);

    // Async reset mid-flush with valids in flight
    do_reset();
    for (int c = 0; c < 13; c++) step(1'b1, 1'b1, c == 10, 1'b0, pat(c));
    chk("mid_recov_pre", W'(recovering), W'(1));
    #2;
    arst = 1'b1;
    #1;
    chk("mid_dout", dout, '0);
    chk("mid_valid", W'(dout_valid), '0);
    chk("mid_recov", W'(recovering), '0);
    chk("mid_sticky", W'(err_sticky), '0);
    chk("mid_count", W'(err_count), '0);
    @(posedge clk);
    #1;
    arst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, pat(300 + i));
      chk($sformatf("post_idle[%0d]", i), W'(dout_valid), '0);
    end
    step(1'b1, 1'b1, 1'b0, 1'b0, pat(400));
    chk("post_k0", W'(dout_valid), '0);
    for (int k = 1; k <= 14; k++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, pat(400 + k));
      chk($sformatf("post_k%0d", k), W'(dout_valid), W'(k == int'(L)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
